// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory responder
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Source of the value presented on readdata
  typedef enum logic [1:0] {
    RD_ZERO   = 2'd0,
    RD_ARRAY  = 2'd1,
    RD_POISON = 2'd2
  } rd_src_t;

  localparam logic [31:0] POISON      = 32'hDEADBEEF;
  localparam int          LATENCY_MIN = 1;
  localparam int          LATENCY_MAX = 15;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM, synchronous write and synchronous read
module dmem_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [31:0]          wd,
  output logic [31:0]          rd
);

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
    if (re) rd <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with pipeline stall
// Optional: DMEM_MISALIGN_TRAP_EN suppresses misaligned stores and poisons misaligned loads.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                 state, state_next;
  logic [3:0]             count;
  logic                   cap_wr, cap_mis;
  logic [ADDR_BITS-1:0]   cap_idx;
  logic [31:0]            cap_wd;
  rd_src_t                rd_src;
  logic [31:0]            array_rd;

  logic                   req, accept, commit, mis_live;
  logic                   cm_wr, cm_mis;
  logic [ADDR_BITS-1:0]   cm_idx;
  logic [31:0]            cm_wd;

  assign req    = memread | memwrite;
  assign accept = (state == IDLE) && req && !reset;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_live = |addr[1:0];
`else
  assign mis_live = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, addr[31:ADDR_BITS+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (LATENCY == 1) ? DONE : BUSY;
      BUSY:    if (count == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A single-cycle access commits straight from the live inputs; longer ones use the capture.
  always_comb begin
    stall  = 1'b0;
    done   = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE: begin
        stall  = req;
        commit = req && (LATENCY == 1);
      end
      BUSY: begin
        stall  = 1'b1;
        commit = (count == 4'd0);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    if (reset) begin
      stall  = 1'b0;
      commit = 1'b0;
    end
    cm_wr  = (state == IDLE) ? memwrite                  : cap_wr;
    cm_mis = (state == IDLE) ? mis_live                  : cap_mis;
    cm_idx = (state == IDLE) ? addr[ADDR_BITS+1:2]       : cap_idx;
    cm_wd  = (state == IDLE) ? writedata                 : cap_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
      err   <= 1'b0;
      rd_src <= RD_ZERO;
    end else begin
      if (accept) begin
        count   <= CNT_INIT;
        cap_wr  <= memwrite;
        cap_mis <= mis_live;
        cap_idx <= addr[ADDR_BITS+1:2];
        cap_wd  <= writedata;
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if ((accept && memread && memwrite) || (commit && cm_mis)) err <= 1'b1;
      if (commit && !cm_wr) rd_src <= cm_mis ? RD_POISON : RD_ARRAY;
    end
  end

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk (clk),
    .we  (commit && cm_wr && !cm_mis),
    .re  (commit && !cm_wr && !cm_mis),
    .idx (cm_idx),
    .wd  (cm_wd),
    .rd  (array_rd)
  );

  always_comb begin
    case (rd_src)
      RD_ARRAY:  readdata = array_rd;
      RD_POISON: readdata = POISON;
      default:   readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, mr2, mw2, rst1, mr1, mw1;
  logic [31:0] a2, wd2, a1, wd1;
  logic [31:0] rd2, rd1;
  logic        stall2, done2, err2, stall1, done1, err1;

  dmem_responder #(.ADDR_BITS(8), .LATENCY(2)) u2 (
    .clk(clk), .reset(rst2), .memread(mr2), .memwrite(mw2), .addr(a2),
    .writedata(wd2), .readdata(rd2), .stall(stall2), .done(done2), .err(err2)
  );

  dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst1), .memread(mr1), .memwrite(mw1), .addr(a1),
    .writedata(wd1), .readdata(rd1), .stall(stall1), .done(done1), .err(err1)
  );

  logic        sel = 1'b0;
  wire         stall_s = sel ? stall1 : stall2;
  wire         done_s  = sel ? done1  : done2;
  wire         err_s   = sel ? err1   : err2;
  wire  [31:0] rd_s    = sel ? rd1    : rd2;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic which, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (which) begin mr1 = rd; mw1 = wr; a1 = a; wd1 = wd; end
    else       begin mr2 = rd; mw2 = wr; a2 = a; wd2 = wd; end
  endtask

  // Request is held through the DONE cycle, as the CPU would, then dropped.
  task automatic access(input logic which, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_stalls, input logic chk, input logic [31:0] exp_rd);
    int n;
    logic [31:0] want;
    sel = which;
    if (chk) sb.push_back(exp_rd);
    @(posedge clk); #1;
    drive(which, rd, wr, a, wd);
    n = 0;
    @(negedge clk);
    while (stall_s === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(n), 32'(exp_stalls));
    check("done_pulse", {31'd0, done_s}, 32'd1);
    if (chk) begin
      want = sb.pop_front();
      check("readdata", rd_s, want);
    end
    @(posedge clk); #1;
    drive(which, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("post_done_low", {31'd0, done_s}, 32'd0);
    check("post_stall_low", {31'd0, stall_s}, 32'd0);
  endtask

  task automatic do_reset(input logic which);
    if (which) rst1 = 1'b1; else rst2 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    if (which) rst1 = 1'b0; else rst2 = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("reset_readdata", rd2, 32'd0);
    check("reset_stall", {31'd0, stall2}, 32'd0);
    check("reset_done", {31'd0, done2}, 32'd0);
    check("reset_err", {31'd0, err2}, 32'd0);

    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h12345678, 2, 1'b0, 32'd0);
    check("store_no_rd_change", rd2, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 2, 1'b1, 32'h12345678);
    access(1'b0, 1'b1, 1'b0, 32'h410, 32'd0, 2, 1'b1, 32'h12345678);
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h11112222, 2, 1'b0, 32'd0);
    check("rd_held_after_store", rd2, 32'h12345678);

    // Reset during the first BUSY cycle aborts the store
    sel = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFF0000);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(negedge clk);
    check("stall_in_reset", {31'd0, stall2}, 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("abort_stall", {31'd0, stall2}, 32'd0);
    check("abort_done", {31'd0, done2}, 32'd0);
    check("abort_readdata", rd2, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 2, 1'b1, 32'h11112222);

    // Simultaneous read and write behaves as a store and latches err
    access(1'b0, 1'b1, 1'b1, 32'h30, 32'h0BADF00D, 2, 1'b0, 32'd0);
    check("err_set", {31'd0, err2}, 32'd1);
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 2, 1'b1, 32'h0BADF00D);
    check("err_sticky", {31'd0, err2}, 32'd1);
    do_reset(1'b0);
    @(negedge clk);
    check("err_cleared", {31'd0, err2}, 32'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
    access(1'b0, 1'b0, 1'b1, 32'h31, 32'hCAFEF00D, 2, 1'b0, 32'd0);
    check("mis_store_err", {31'd0, err_s}, 32'd1);
    access(1'b0, 1'b1, 1'b0, 32'h32, 32'd0, 2, 1'b1, 32'hDEADBEEF);
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 2, 1'b1, 32'h0BADF00D);
`else
    access(1'b0, 1'b0, 1'b1, 32'h41, 32'h11223344, 2, 1'b0, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h42, 32'd0, 2, 1'b1, 32'h11223344);
    check("unaligned_no_err", {31'd0, err_s}, 32'd0);
`endif

    access(1'b1, 1'b0, 1'b1, 32'h04, 32'hA5A5A5A5, 1, 1'b0, 32'd0);
    access(1'b1, 1'b1, 1'b0, 32'h08, 32'd0, 1, 1'b0, 32'd0);
    access(1'b1, 1'b1, 1'b0, 32'h04, 32'd0, 1, 1'b1, 32'hA5A5A5A5);
    check("l1_err_clear", {31'd0, err_s}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
